// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 capture path: state encoding, colour and
// address bit positions, and width helpers.
package hub75_pkg;

   typedef enum logic {
      ST_SHIFT  = 1'b0,
      ST_COMMIT = 1'b1
   } state_t;

   // Bit positions inside the 6-bit colour bus {R1,G1,B1,R2,G2,B2}
   localparam int RGB_R1 = 5;
   localparam int RGB_G1 = 4;
   localparam int RGB_B1 = 3;
   localparam int RGB_R2 = 2;
   localparam int RGB_G2 = 1;
   localparam int RGB_B2 = 0;

   // Bit positions inside the row address bus {E,D,C,B,A}
   localparam int ADDR_A = 0;
   localparam int ADDR_B = 1;
   localparam int ADDR_C = 2;
   localparam int ADDR_D = 3;
   localparam int ADDR_E = 4;

   // Index width able to address 'count' entries (at least one bit)
   function automatic int col_width(input int count);
      return (count <= 2) ? 1 : $clog2(count);
   endfunction

   function automatic int row_width(input int count);
      return (count <= 2) ? 1 : $clog2(count);
   endfunction

endpackage

// File: rtl/hub75_sync_edge.sv
// Two-flop synchroniser followed by a delay flop. 'level' is the synchronised
// input, 'rise' flags a 0->1 transition of the synchronised value.
module hub75_sync_edge #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
)(
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] din,
   output logic [W-1:0] level,
   output logic [W-1:0] rise
);

   logic [W-1:0] meta;
   logic [W-1:0] sync;
   logic [W-1:0] dly;

   // Synchroniser chain plus one-cycle delay for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= RST_VAL;
         sync <= RST_VAL;
         dly  <= RST_VAL;
      end else begin
         meta <= din;
         sync <= meta;
         dly  <= sync;
      end
   end

   assign level = sync;
   assign rise  = sync & ~dly;

endmodule

// File: rtl/hub75_capture.sv
// HUB75 receive-side capture: rebuilds each latched row from the shift clock
// and colour lines, then streams it out as {row, column} pixel writes.
module hub75_capture
   import hub75_pkg::*;
#(
   parameter int SCREEN_WIDTH = 32,
   parameter int SCREEN_DEPTH = 16,
   parameter int COL_W        = 6,
   parameter int ROW_W        = 5
)(
   input  logic                   clk_in,
   input  logic                   reset,
   input  logic                   hub_clk,
   input  logic                   hub_lat,
   input  logic                   hub_oe_n,
   input  logic [ROW_W-1:0]       hub_addr,
   input  logic [5:0]             hub_rgb,
   output logic                   wr_en,
   input  logic                   wr_ready,
   output logic [ROW_W+COL_W-1:0] wr_addr,
   output logic [5:0]             wr_data,
   output logic                   frame_done,
   output logic                   oe_active,
   output logic                   err_overflow,
   output logic                   err_overrun
);

   // Counters need one extra bit so they can hold SCREEN_WIDTH itself
   localparam int                CNT_W     = COL_W + 1;
   localparam int                BUF_DEPTH = 1 << COL_W;
   localparam logic [CNT_W-1:0]  WIDTH_C   = CNT_W'(SCREEN_WIDTH);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(SCREEN_DEPTH - 1);

   logic             clk_rise;
   logic             lat_rise;
   logic             oe_n_sync;
   logic [ROW_W-1:0] addr_sync;
   logic [5:0]       rgb_sync;

   logic             clk_level_unused;
   logic             lat_level_unused;
   logic             oe_rise_unused;
   logic [ROW_W-1:0] addr_rise_unused;
   logic [5:0]       rgb_rise_unused;

   hub75_sync_edge #(.W(1), .RST_VAL(1'b0)) u_sync_clk (
      .clk(clk_in), .reset(reset), .din(hub_clk),
      .level(clk_level_unused), .rise(clk_rise)
   );

   hub75_sync_edge #(.W(1), .RST_VAL(1'b0)) u_sync_lat (
      .clk(clk_in), .reset(reset), .din(hub_lat),
      .level(lat_level_unused), .rise(lat_rise)
   );

   hub75_sync_edge #(.W(1), .RST_VAL(1'b1)) u_sync_oe (
      .clk(clk_in), .reset(reset), .din(hub_oe_n),
      .level(oe_n_sync), .rise(oe_rise_unused)
   );

   hub75_sync_edge #(.W(ROW_W), .RST_VAL('0)) u_sync_addr (
      .clk(clk_in), .reset(reset), .din(hub_addr),
      .level(addr_sync), .rise(addr_rise_unused)
   );

   hub75_sync_edge #(.W(6), .RST_VAL(6'd0)) u_sync_rgb (
      .clk(clk_in), .reset(reset), .din(hub_rgb),
      .level(rgb_sync), .rise(rgb_rise_unused)
   );

   assign oe_active = ~oe_n_sync;

   state_t           state;
   logic [CNT_W-1:0] col_cnt;
   logic [CNT_W-1:0] commit_len;
   logic [CNT_W-1:0] wr_col;
   logic [CNT_W-1:0] wr_col_next;
   logic [ROW_W-1:0] row_reg;
   logic [5:0]       line_buf [BUF_DEPTH];
   logic             shift_store;

   assign shift_store = (state == ST_SHIFT) && clk_rise && (col_cnt < WIDTH_C);
   assign wr_col_next = wr_col + 1'b1;

   // Line buffer fill; only written while shifting, never during a commit
   always_ff @(posedge clk_in) begin
      if (shift_store) begin
         line_buf[col_cnt[COL_W-1:0]] <= rgb_sync;
      end
   end

   // Shift/commit sequencer with registered write-port outputs and flags
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state        <= ST_SHIFT;
         col_cnt      <= '0;
         commit_len   <= '0;
         wr_col       <= '0;
         row_reg      <= '0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         frame_done   <= 1'b0;
         err_overflow <= 1'b0;
         err_overrun  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_SHIFT: begin
               if (clk_rise && (col_cnt == WIDTH_C)) begin
                  err_overflow <= 1'b1;
               end
               if (lat_rise) begin
                  // A pixel arriving with the latch is stored and belongs to this row,
                  // so column 0 is forwarded directly when it is that pixel.
                  row_reg    <= addr_sync;
                  col_cnt    <= '0;
                  wr_col     <= '0;
                  commit_len <= shift_store ? (col_cnt + 1'b1) : col_cnt;
                  wr_en      <= shift_store || (col_cnt != '0);
                  wr_addr    <= {addr_sync, COL_W'(0)};
                  wr_data    <= (shift_store && (col_cnt == '0)) ? rgb_sync : line_buf[0];
                  state      <= ST_COMMIT;
               end else if (shift_store) begin
                  col_cnt <= col_cnt + 1'b1;
               end
            end
            ST_COMMIT: begin
               if (clk_rise || lat_rise) begin
                  err_overrun <= 1'b1;
               end
               if (!wr_en) begin
                  // Empty row: nothing to write
                  state <= ST_SHIFT;
               end else if (wr_ready) begin
                  if (wr_col_next == commit_len) begin
                     wr_en      <= 1'b0;
                     frame_done <= (row_reg == LAST_ROW);
                     state      <= ST_SHIFT;
                  end else begin
                     wr_col  <= wr_col_next;
                     wr_addr <= {row_reg, wr_col_next[COL_W-1:0]};
                     wr_data <= line_buf[wr_col_next[COL_W-1:0]];
                  end
               end
            end
            default: state <= ST_SHIFT;
         endcase
      end
   end

endmodule
